// File: rtl/ternary_sampler_stream.sv
// Streaming mod-3 ternary sampler: LANES uniform bytes per beat become LANES
// 2-bit coefficients through a two-stage, backpressure-aware pipeline.
//   state | meaning
//   IDLE  | waiting for start, no input accepted
//   RUN   | accepting input beats 0..BEATS-1
//   DRAIN | all input taken, waiting for the out_last handshake
module ternary_sampler_stream #(
   parameter int NCOEF = 700,
   parameter int LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*LANES-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*LANES-1:0]   out_coef,
   output logic [LANES-1:0]     out_keep,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   localparam int BEATS  = (NCOEF + LANES - 1) / LANES;
   localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LAST_N = NCOEF - (BEATS - 1) * LANES;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t               state_q, state_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 mode_q, mode_d;
   logic [CW-1:0]        in_cnt_q, in_cnt_d;
   logic [CW-1:0]        out_cnt_q, out_cnt_d;
   logic                 a_valid_q, a_valid_d;
   logic [4*LANES-1:0]   a_sum_q, a_sum_d;
   logic [LANES-1:0]     a_keep_q, a_keep_d;
   logic                 a_last_q, a_last_d;
   logic                 b_valid_q, b_valid_d;
   logic [2*LANES-1:0]   b_coef_q, b_coef_d;
   logic [LANES-1:0]     b_keep_q, b_keep_d;
   logic                 b_last_q, b_last_d;

   logic a_adv, in_fire, out_fire, last_in;

   // Partial sums stay within 0..12, so only 13 table entries matter.
   function automatic logic [1:0] mod3(input logic [3:0] s);
      case (s)
         4'd0, 4'd3, 4'd6, 4'd9, 4'd12: mod3 = 2'd0;
         4'd1, 4'd4, 4'd7, 4'd10:       mod3 = 2'd1;
         default:                       mod3 = 2'd2;
      endcase
   endfunction

   assign a_adv    = a_valid_q && (!b_valid_q || out_ready);
   assign in_ready = (state_q == RUN) && (!a_valid_q || a_adv);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = b_valid_q && out_ready;
   assign last_in  = (in_cnt_q == LAST_BEAT);

   always_comb begin
      logic [7:0] lane_b;
      logic [3:0] lane_s;
      logic [1:0] lane_r;
      logic       lane_k;
      lane_b    = '0;
      lane_s    = '0;
      lane_r    = '0;
      lane_k    = 1'b0;
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      mode_d    = mode_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      a_valid_d = a_valid_q;
      a_sum_d   = a_sum_q;
      a_keep_d  = a_keep_q;
      a_last_d  = a_last_q;
      b_valid_d = b_valid_q;
      b_coef_d  = b_coef_q;
      b_keep_d  = b_keep_q;
      b_last_d  = b_last_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               busy_d    = 1'b1;
               mode_d    = signed_mode;
               in_cnt_d  = '0;
               out_cnt_d = '0;
            end
         end
         RUN: begin
            if (in_fire) begin
               in_cnt_d = last_in ? '0 : in_cnt_q + 1'b1;
               if (last_in) state_d = DRAIN;
            end
         end
         default: ;
      endcase

      if (out_fire) begin
         if (out_cnt_q == LAST_BEAT) begin
            out_cnt_d = '0;
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
         end else begin
            out_cnt_d = out_cnt_q + 1'b1;
         end
      end

      // Stage A: fold bit pairs (4 == 1 mod 3) and mask lanes past NCOEF.
      if (in_fire) begin
         a_valid_d = 1'b1;
         a_last_d  = last_in;
         for (int k = 0; k < LANES; k++) begin
            lane_b = in_data[8*k +: 8];
            lane_k = !last_in || (k < LAST_N);
            lane_s = {2'b00, lane_b[1:0]} + {2'b00, lane_b[3:2]}
                   + {2'b00, lane_b[5:4]} + {2'b00, lane_b[7:6]};
            a_keep_d[k]       = lane_k;
            a_sum_d[4*k +: 4] = lane_k ? lane_s : 4'd0;
         end
      end else if (a_adv) begin
         a_valid_d = 1'b0;
      end

      // Stage B: final reduction and encoding; this is the output register.
      if (a_adv) begin
         b_valid_d = 1'b1;
         b_keep_d  = a_keep_q;
         b_last_d  = a_last_q;
         for (int k = 0; k < LANES; k++) begin
            lane_r = mod3(a_sum_q[4*k +: 4]);
            b_coef_d[2*k +: 2] = (mode_q && lane_r == 2'd2) ? 2'b11 : lane_r;
         end
      end else if (out_fire) begin
         b_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mode_q    <= 1'b0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         a_valid_q <= 1'b0;
         a_sum_q   <= '0;
         a_keep_q  <= '0;
         a_last_q  <= 1'b0;
         b_valid_q <= 1'b0;
         b_coef_q  <= '0;
         b_keep_q  <= '0;
         b_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         mode_q    <= mode_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         a_valid_q <= a_valid_d;
         a_sum_q   <= a_sum_d;
         a_keep_q  <= a_keep_d;
         a_last_q  <= a_last_d;
         b_valid_q <= b_valid_d;
         b_coef_q  <= b_coef_d;
         b_keep_q  <= b_keep_d;
         b_last_q  <= b_last_d;
      end
   end

   assign out_valid = b_valid_q;
   assign out_coef  = b_coef_q;
   assign out_keep  = b_keep_q;
   assign out_last  = b_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ternary_sampler_stream.sv
// Directed bench for ternary_sampler_stream: a 4-lane/256-coef instance and a
// 3-lane/700-coef instance share one stimulus path selected by sel.
module tb_ternary_sampler_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, signed_mode, in_valid, out_ready, sel;
   logic [31:0] in_data;

   logic       in_ready_a, out_valid_a, out_last_a, busy_a, done_a;
   logic [7:0] out_coef_a;
   logic [3:0] out_keep_a;
   logic       in_ready_b, out_valid_b, out_last_b, busy_b, done_b;
   logic [5:0] out_coef_b;
   logic [2:0] out_keep_b;

   logic       in_ready_m, out_valid_m, out_last_m, busy_m, done_m;
   logic [7:0] out_coef_m;
   logic [3:0] out_keep_m;

   ternary_sampler_stream #(.NCOEF(256), .LANES(4)) dut_a (
      .clk(clk), .rst(rst), .start(start & ~sel), .signed_mode(signed_mode),
      .in_valid(in_valid & ~sel), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_coef(out_coef_a),
      .out_keep(out_keep_a), .out_last(out_last_a), .busy(busy_a), .done(done_a));

   ternary_sampler_stream #(.NCOEF(700), .LANES(3)) dut_b (
      .clk(clk), .rst(rst), .start(start & sel), .signed_mode(signed_mode),
      .in_valid(in_valid & sel), .in_ready(in_ready_b), .in_data(in_data[23:0]),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_coef(out_coef_b),
      .out_keep(out_keep_b), .out_last(out_last_b), .busy(busy_b), .done(done_b));

   assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
   assign out_valid_m = sel ? out_valid_b : out_valid_a;
   assign out_last_m  = sel ? out_last_b  : out_last_a;
   assign busy_m      = sel ? busy_b      : busy_a;
   assign done_m      = sel ? done_b      : done_a;
   assign out_coef_m  = sel ? {2'b00, out_coef_b} : out_coef_a;
   assign out_keep_m  = sel ? {1'b0, out_keep_b}  : out_keep_a;

   int n_cmp = 0;
   int n_bad = 0;
   int l_cur, n_cur, beats_cur;
   int first_in_cyc, first_out_cyc, last_out_cyc, kept_total;
   logic [7:0] first_coef, last_coef;
   logic [3:0] last_keep;

   function automatic logic [7:0] byte_of(input int idx, input int pat);
      int t;
      t = idx;
      if (pat == 1) t = idx * 37 + 11;
      if (pat == 2) begin
         case (idx % 4)
            0: t = 'h80;
            1: t = 'h07;
            2: t = 'h03;
            default: t = 'h05;
         endcase
      end
      return t[7:0];
   endfunction

   function automatic logic [1:0] enc(input logic [7:0] b, input logic mode);
      int r;
      r = int'(b) % 3;
      if (mode && r == 2) return 2'b11;
      return 2'(r);
   endfunction

   task automatic select(input logic s);
      sel       = s;
      l_cur     = s ? 3 : 4;
      n_cur     = s ? 700 : 256;
      beats_cur = (n_cur + l_cur - 1) / l_cur;
   endtask

   // One full run on the selected instance, checked beat by beat against the model.
   task automatic run(input logic mode, input int pat, input bit rnd_in, input bit rnd_out,
                      input int restart_at, input string tag);
      int ib, ob, cyc, idx;
      bit done_seen, stall_prev;
      logic [7:0] sv_coef, exp_coef;
      logic [3:0] sv_keep, exp_keep;
      logic sv_last, exp_last;
      ib = 0; ob = 0; cyc = 0; done_seen = 0; stall_prev = 0;
      sv_coef = '0; sv_keep = '0; sv_last = 1'b0;
      first_in_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; kept_total = 0;
      signed_mode = mode;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      signed_mode = ~mode;
      while (!done_seen && cyc < 6000) begin
         in_valid = (ib >= beats_cur) ? 1'b1 : (rnd_in ? 1'($urandom_range(0, 1)) : 1'b1);
         in_data = '0;
         for (int k = 0; k < l_cur; k++) in_data[8*k +: 8] = byte_of(ib * l_cur + k, pat);
         out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
         start = (cyc == restart_at);
         #1;
         if (cyc == 0) begin
            n_cmp++;
            if (busy_m !== 1'b1) begin
               n_bad++;
               $display("FAIL %s busy_after_start: got %b want 1", tag, busy_m);
            end
         end
         if (stall_prev) begin
            n_cmp++;
            if ({out_valid_m, out_last_m, out_keep_m, out_coef_m} !== {1'b1, sv_last, sv_keep, sv_coef}) begin
               n_bad++;
               $display("FAIL %s stall_hold cyc %0d: got v%b l%b k%h c%h want v1 l%b k%h c%h", tag, cyc,
                        out_valid_m, out_last_m, out_keep_m, out_coef_m, sv_last, sv_keep, sv_coef);
            end
         end
         if (first_out_cyc < 0 && out_valid_m) first_out_cyc = cyc;
         if (ib >= beats_cur) begin
            n_cmp++;
            if (in_ready_m !== 1'b0) begin
               n_bad++;
               $display("FAIL %s extra_beat_stall cyc %0d: in_ready %b want 0", tag, cyc, in_ready_m);
            end
         end else if (in_valid && in_ready_m) begin
            if (first_in_cyc < 0) first_in_cyc = cyc;
            ib++;
         end
         if (out_valid_m && out_ready) begin
            exp_coef = '0;
            exp_keep = '0;
            for (int k = 0; k < l_cur; k++) begin
               idx = ob * l_cur + k;
               if (idx < n_cur) begin
                  exp_keep[k] = 1'b1;
                  exp_coef[2*k +: 2] = enc(byte_of(idx, pat), mode);
               end
            end
            exp_last = (ob == beats_cur - 1);
            n_cmp++;
            if ({out_last_m, out_keep_m, out_coef_m} !== {exp_last, exp_keep, exp_coef}) begin
               n_bad++;
               $display("FAIL %s beat %0d: got l%b k%h c%h want l%b k%h c%h", tag, ob,
                        out_last_m, out_keep_m, out_coef_m, exp_last, exp_keep, exp_coef);
            end
            if (ob == 0) first_coef = out_coef_m;
            last_coef = out_coef_m;
            last_keep = out_keep_m;
            kept_total += $countones(out_keep_m);
            if (exp_last) last_out_cyc = cyc;
            ob++;
         end
         if (done_m) begin
            done_seen = 1;
            n_cmp++;
            if (ob != beats_cur || cyc != last_out_cyc + 1 || busy_m !== 1'b0) begin
               n_bad++;
               $display("FAIL %s done_timing: beats %0d cyc %0d busy %b want beats %0d cyc %0d busy 0",
                        tag, ob, cyc, busy_m, beats_cur, last_out_cyc + 1);
            end
         end
         stall_prev = out_valid_m && !out_ready;
         sv_coef = out_coef_m;
         sv_keep = out_keep_m;
         sv_last = out_last_m;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if (!done_seen) begin
         n_bad++;
         $display("FAIL %s done_timeout: no done after %0d cycles, want done", tag, cyc);
      end
      n_cmp++;
      if (kept_total != n_cur) begin
         n_bad++;
         $display("FAIL %s kept_total: got %0d want %0d", tag, kept_total, n_cur);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; signed_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0;
      select(0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({in_ready_a, out_valid_a, out_last_a, busy_a, done_a, out_coef_a, out_keep_a} !== 17'd0) begin
         n_bad++;
         $display("FAIL reset_a: got rdy%b v%b l%b b%b d%b c%h k%h want all 0", in_ready_a, out_valid_a,
                  out_last_a, busy_a, done_a, out_coef_a, out_keep_a);
      end
      n_cmp++;
      if ({in_ready_b, out_valid_b, out_last_b, busy_b, done_b, out_coef_b, out_keep_b} !== 14'd0) begin
         n_bad++;
         $display("FAIL reset_b: got rdy%b v%b l%b b%b d%b c%h k%h want all 0", in_ready_b, out_valid_b,
                  out_last_b, busy_b, done_b, out_coef_b, out_keep_b);
      end
      rst = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_in_valid: in_ready %b out_valid %b want 0 0", in_ready_a, out_valid_a);
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_sweep();
      select(0);
      run(1'b0, 0, 0, 0, -1, "sweep");
      n_cmp++;
      if (first_out_cyc != first_in_cyc + 2) begin
         n_bad++;
         $display("FAIL latency: first out cyc %0d want %0d", first_out_cyc, first_in_cyc + 2);
      end
      n_cmp++;
      if (last_out_cyc - first_out_cyc != 63) begin
         n_bad++;
         $display("FAIL throughput: span %0d want 63", last_out_cyc - first_out_cyc);
      end
      n_cmp++;
      if (first_coef !== 8'h24 || last_coef !== 8'h24 || last_keep !== 4'hF) begin
         n_bad++;
         $display("FAIL sweep_ends: first %h last %h keep %h want 24 24 f", first_coef, last_coef, last_keep);
      end
   endtask

   task automatic test_signed();
      select(0);
      run(1'b1, 2, 0, 0, 10, "signed");
      n_cmp++;
      if (first_coef !== 8'hC7 || last_coef !== 8'hC7) begin
         n_bad++;
         $display("FAIL signed_coef: first %h last %h want c7 c7", first_coef, last_coef);
      end
   endtask

   task automatic test_partial();
      select(1);
      run(1'b0, 1, 0, 0, -1, "partial");
      n_cmp++;
      if (last_keep !== 4'b0001 || last_coef !== 8'h00) begin
         n_bad++;
         $display("FAIL partial_last: keep %b coef %h want 0001 00", last_keep, last_coef);
      end
   endtask

   task automatic test_backpressure();
      select(1);
      run(1'b0, 1, 1, 1, -1, "backpressure");
      select(0);
      run(1'b1, 1, 1, 1, 7, "backpressure_a");
   endtask

   task automatic test_reset_mid();
      int ib, cyc;
      bit saw_done;
      select(0);
      ib = 0; cyc = 0; saw_done = 0;
      signed_mode = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (ib < 50 && cyc < 200) begin
         in_valid = 1'b1;
         for (int k = 0; k < 4; k++) in_data[8*k +: 8] = byte_of(ib * 4 + k, 0);
         #1;
         if (in_ready_a) ib++;
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (ib != 50) begin
         n_bad++;
         $display("FAIL reset_mid_feed: accepted %0d want 50", ib);
      end
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({in_ready_a, out_valid_a, out_last_a, busy_a, done_a, out_coef_a, out_keep_a} !== 17'd0) begin
         n_bad++;
         $display("FAIL reset_mid: got rdy%b v%b l%b b%b d%b c%h k%h want all 0", in_ready_a, out_valid_a,
                  out_last_a, busy_a, done_a, out_coef_a, out_keep_a);
      end
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         #1;
         if (done_a || out_valid_a) saw_done = 1;
      end
      n_cmp++;
      if (saw_done) begin
         n_bad++;
         $display("FAIL reset_mid_quiet: done/out_valid seen %b want 0", saw_done);
      end
      @(negedge clk);
      run(1'b0, 0, 0, 0, -1, "after_reset");
   endtask

   task automatic test_back_to_back();
      select(0);
      run(1'b0, 0, 0, 0, -1, "b2b_first");
      n_cmp++;
      if (first_coef !== 8'h24) begin
         n_bad++;
         $display("FAIL b2b_first_coef: got %h want 24", first_coef);
      end
      run(1'b1, 0, 0, 0, -1, "b2b_second");
      n_cmp++;
      if (first_coef !== 8'h34) begin
         n_bad++;
         $display("FAIL b2b_second_coef: got %h want 34", first_coef);
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_signed();
      test_partial();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ternary_sampler_stream.md
Name: ternary_sampler_stream

Overview:
- Streaming, parametrised ternary sampler for the NTRU-HRSS key-generation path.
- Consumes a uniform random bit string in LANES-byte beats and reduces each byte mod 3 into one ternary coefficient.
- Emits coefficients as a handshaked stream to the polynomial buffer.
- Run length, lane count and output encoding are configurable; a run is framed by start/done.

Parameters:
- NCOEF, 700, coefficients per run (one input byte each); must be ≥1.
- LANES, 4, bytes consumed and coefficients produced per beat; 1..32.
- BEATS, derived = ceil(NCOEF/LANES), input/output beats per run.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse, begins a run
- signed_mode  input  1  sampled at start; 0: coef 2'b00/01/10 = 0/1/2; 1: 2'b00/01/11 = 0/+1/-1
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid&&in_ready
- in_data  input  8*LANES  byte k at bits [8k+7:8k]; lane 0 = lowest byte = lowest coefficient index
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts
- out_coef  output  2*LANES  lane k at bits [2k+1:2k]
- out_keep  output  LANES  per-lane valid mask; all ones except possibly the last beat
- out_last  output  1  marks final beat of run
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after last output beat handshakes

Behaviour:
- Reset values: state IDLE; busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_keep=0, out_coef=0; beat counters=0; both pipeline valid bits cleared.
- FSM IDLE -> RUN on start. RUN -> DRAIN when input beat BEATS-1 is accepted. DRAIN -> IDLE when beat with out_last handshakes; done pulses in that cycle's successor (registered), busy falls with it.
- start outside IDLE: ignored. signed_mode latched on the accepted start; changes mid-run have no effect.
- in_ready = (state==RUN) && stage-A slot free or advancing. Input is never accepted in IDLE/DRAIN; extra input after BEATS beats is stalled, not dropped.
- Stage A (registered), per lane: s = b[1:0]+b[3:2]+b[5:4]+b[7:6] (4 bits, max 12); 4≡1 mod 3, so s≡b mod 3.
- Stage B (registered = output register), per lane: r = s mod 3 in {0,1,2}; encoded per the latched mode.
- Stage A also carries keep and last. On the final beat, keep lanes < NCOEF-(BEATS-1)*LANES; upper lanes have coef 2'b00 and keep 0.
- Latency: 2 cycles from input handshake to out_valid with out_ready held high; full throughput of 1 beat/cycle.
- Backpressure: a stage advances when its successor is empty or advancing. out_coef/out_keep/out_last are held stable while out_valid && !out_ready. No bubbles are inserted when out_ready=1.
- Output beat counter increments per output handshake; out_last is asserted exactly on beat BEATS-1.
- Reset mid-run: aborts immediately, pipeline flushed, no done pulse.
- NCOEF a multiple of LANES: the last beat has out_keep all ones.
- LANES=1 degenerates to byte-serial operation with identical arithmetic.

Test Plan:
- Arithmetic sweep: LANES=4, NCOEF=256, in_data bytes 0..255 in order, signed_mode=0 -> coef[i] = i mod 3; bytes 0xFF->0, 0x80->2, 0x07->1, 0x05->2; 64 beats, out_last on beat 63, done one cycle after.
- Signed mode: bytes {0x80,0x07,0x03,0x05}, signed_mode=1 -> out_coef = {2'b11,2'b00,2'b01,2'b11} (lane3..lane0).
- Partial last beat: NCOEF=700, LANES=3 -> 234 beats; final out_keep=3'b001, upper lanes 2'b00; total kept coefficients 700.
- Backpressure: random out_ready (~50%) and random in_valid across a 700-coefficient run -> output sequence identical to the unstalled run, no loss or duplication; outputs stable while stalled; throughput 1 beat/cycle when both sides are held high.
- Control edges: start while busy -> ignored, counters unchanged; in_valid in IDLE -> in_ready=0; extra beat after BEATS beats stalls; rst asserted at beat 50 -> all outputs at reset values next cycle; a fresh start then completes a full correct run.
- Back-to-back runs: start in the cycle after done, with signed_mode toggled -> second run uses the new encoding; first run unaffected.
